// File: rtl/clock_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : clock_timekeeper
// Description : Time-of-day core. Keeps seconds/minutes/hours counters that
//               free-run from a prescaled clock enable in run mode. In set
//               mode the field chosen by i_sel loads i_val when i_val is in
//               range. o_sel_val returns the selected field for the input
//               stage's value counter preload.
// Ports       : i_clk, i_reset (sync, active high), i_ena (prescaler enable),
//               i_set (1 = set mode), i_sel (0 sec/1 min/2 hr/3 none),
//               i_val (field value), o_sec/o_min/o_hr (binary time),
//               o_sel_val (selected field, 0 for none), o_sec_pulse (one
//               cycle per second tick), o_running (registered ~i_set).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_timekeeper #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned HOURS_PER_DAY = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_set,
    input  logic [1:0] i_sel,
    input  logic [7:0] i_val,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic [7:0] o_hr,
    output logic [7:0] o_sel_val,
    output logic       o_sec_pulse,
    output logic       o_running
);

    localparam int unsigned c_PRESC_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] c_MAX_SM     = 8'd59;
    localparam logic [7:0] c_MAX_HR     = 8'(HOURS_PER_DAY - 1);

    localparam logic [1:0] c_SEL_SEC    = 2'd0;
    localparam logic [1:0] c_SEL_MIN    = 2'd1;
    localparam logic [1:0] c_SEL_HR     = 2'd2;

    logic [c_PRESC_W-1:0] r_presc;
    logic [7:0]           r_sec;
    logic [7:0]           r_min;
    logic [7:0]           r_hr;
    logic                 r_sec_pulse;
    logic                 r_running;

    logic                 w_presc_wrap;
    logic                 w_tick;

    assign w_presc_wrap = (r_presc == c_PRESC_MAX);
    // A tick needs run mode and an enabled cycle on the last prescaler count.
    assign w_tick       = i_ena & ~i_set & w_presc_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc     <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= '0;
            r_sec_pulse <= 1'b0;
            r_running   <= 1'b1;
        end else begin
            r_sec_pulse <= w_tick;
            r_running   <= ~i_set;
            if (i_set) begin
                // Discard any partial second so the first run tick comes a
                // full second after leaving set mode.
                r_presc <= '0;
                case (i_sel)
                    c_SEL_SEC: if (i_val <= c_MAX_SM) r_sec <= i_val;
                    c_SEL_MIN: if (i_val <= c_MAX_SM) r_min <= i_val;
                    c_SEL_HR:  if (i_val <= c_MAX_HR) r_hr  <= i_val;
                    default:   ;
                endcase
            end else if (i_ena) begin
                if (w_presc_wrap) begin
                    r_presc <= '0;
                    // Full carry chain resolves in a single edge.
                    if (r_sec == c_MAX_SM) begin
                        r_sec <= '0;
                        if (r_min == c_MAX_SM) begin
                            r_min <= '0;
                            if (r_hr == c_MAX_HR) begin
                                r_hr <= '0;
                            end else begin
                                r_hr <= r_hr + 8'd1;
                            end
                        end else begin
                            r_min <= r_min + 8'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 8'd1;
                    end
                end else begin
                    r_presc <= r_presc + c_PRESC_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_sel_val = 8'd0;
        case (i_sel)
            c_SEL_SEC: o_sel_val = r_sec;
            c_SEL_MIN: o_sel_val = r_min;
            c_SEL_HR:  o_sel_val = r_hr;
            default:   o_sel_val = 8'd0;
        endcase
    end

    assign o_sec       = r_sec;
    assign o_min       = r_min;
    assign o_hr        = r_hr;
    assign o_sec_pulse = r_sec_pulse;
    assign o_running   = r_running;

endmodule
`default_nettype wire

// File: tb/tb_clock_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_timekeeper
// Description : Self-checking bench for clock_timekeeper. A time-of-day model
//               kept as seconds-since-midnight predicts every output; directed
//               sequences are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_timekeeper;

    localparam int unsigned c_TPS = 4;
    localparam int unsigned c_HPD = 24;

    logic       clk;
    logic       i_reset;
    logic       i_ena;
    logic       i_set;
    logic [1:0] i_sel;
    logic [7:0] i_val;
    logic [7:0] o_sec;
    logic [7:0] o_min;
    logic [7:0] o_hr;
    logic [7:0] o_sel_val;
    logic       o_sec_pulse;
    logic       o_running;

    clock_timekeeper #(
        .TICKS_PER_SEC (c_TPS),
        .HOURS_PER_DAY (c_HPD)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_ena       (i_ena),
        .i_set       (i_set),
        .i_sel       (i_sel),
        .i_val       (i_val),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hr        (o_hr),
        .o_sel_val   (o_sel_val),
        .o_sec_pulse (o_sec_pulse),
        .o_running   (o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int pulse_cnt;

    // Reference model: time of day as seconds since midnight.
    int m_tod;
    int m_presc;
    int m_pulse;
    int m_running;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_field(input int sel);
        case (sel)
            0:       return m_tod % 60;
            1:       return (m_tod / 60) % 60;
            2:       return m_tod / 3600;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit ena, input bit set,
                              input int sel, input int val);
        int s, m, h;
        if (rst) begin
            m_tod = 0; m_presc = 0; m_pulse = 0; m_running = 1;
            return;
        end
        m_pulse   = 0;
        m_running = set ? 0 : 1;
        if (set) begin
            m_presc = 0;
            s = m_field(0); m = m_field(1); h = m_field(2);
            if (sel == 0 && val < 60) s = val;
            if (sel == 1 && val < 60) m = val;
            if (sel == 2 && val < int'(c_HPD)) h = val;
            m_tod = h * 3600 + m * 60 + s;
        end else if (ena) begin
            if (m_presc == int'(c_TPS) - 1) begin
                m_presc = 0;
                m_pulse = 1;
                m_tod   = (m_tod + 1) % (int'(c_HPD) * 3600);
            end else begin
                m_presc++;
            end
        end
    endtask

    // One clock: drive inputs, check the mux before the edge, advance model,
    // then check the registered outputs just after the edge.
    task automatic step(input bit rst, input bit ena, input bit set,
                        input int sel, input int val);
        i_reset = rst; i_ena = ena; i_set = set;
        i_sel = 2'(sel); i_val = 8'(val);
        #1;
        if (!rst) check_val("sel_val", int'(o_sel_val), m_field(sel));
        @(posedge clk);
        model_edge(rst, ena, set, sel, val);
        #1;
        if (o_sec_pulse) pulse_cnt++;
        check_val("sec",     int'(o_sec),       m_field(0));
        check_val("min",     int'(o_min),       m_field(1));
        check_val("hr",      int'(o_hr),        m_field(2));
        check_val("pulse",   int'(o_sec_pulse), m_pulse);
        check_val("running", int'(o_running),   m_running);
    endtask

    int mux_exp [4];

    initial begin
        checks = 0; errors = 0; pulse_cnt = 0;
        m_tod = 0; m_presc = 0; m_pulse = 0; m_running = 1;
        i_reset = 1'b1; i_ena = 1'b0; i_set = 1'b0; i_sel = 2'd3; i_val = 8'd0;
        @(posedge clk);
        #1;

        // Reset state and free run for 60 seconds.
        step(1, 0, 0, 3, 0);
        check_val("rst_running", int'(o_running), 1);
        pulse_cnt = 0;
        for (int i = 0; i < 240; i++) step(0, 1, 0, 3, 0);
        check_val("run_pulses", pulse_cnt, 60);
        check_val("run_sec", int'(o_sec), 0);
        check_val("run_min", int'(o_min), 1);

        // Set-mode walk to 23:59:58 then roll over.
        step(0, 1, 1, 2, 23);
        step(0, 1, 1, 1, 59);
        step(0, 1, 1, 0, 58);
        check_val("walk_hr",  int'(o_hr),  23);
        check_val("walk_min", int'(o_min), 59);
        check_val("walk_sec", int'(o_sec), 58);
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) step(0, 1, 0, 3, 0);
        check_val("roll_pulses", pulse_cnt, 2);
        check_val("roll_tod", int'(o_hr) * 3600 + int'(o_min) * 60 + int'(o_sec), 0);

        // Range rejection.
        step(0, 1, 1, 2, 7);
        step(0, 1, 1, 2, 24);
        check_val("rej_hr", int'(o_hr), 7);
        step(0, 1, 1, 0, 33);
        step(0, 1, 1, 0, 60);
        check_val("rej_sec", int'(o_sec), 33);

        // Enable gating: one tick per 8 clocks.
        step(0, 1, 0, 3, 0);
        pulse_cnt = 0;
        for (int i = 0; i < 32; i++) step(0, (i % 2) == 0, 0, 3, 0);
        check_val("gate_pulses", pulse_cnt, 4);

        // Reset at 12:34:56 with prescaler at 2.
        step(0, 1, 1, 2, 12);
        step(0, 1, 1, 1, 34);
        step(0, 1, 1, 0, 56);
        step(0, 1, 0, 3, 0);
        step(0, 1, 0, 3, 0);
        step(1, 1, 0, 3, 0);
        check_val("mid_rst_sec",   int'(o_sec), 0);
        check_val("mid_rst_pulse", int'(o_sec_pulse), 0);
        check_val("mid_rst_run",   int'(o_running), 1);
        step(0, 1, 1, 0, 30);
        step(1, 1, 1, 0, 30);
        check_val("rst_over_set", int'(o_sec), 0);

        // Mux in the same cycle as i_sel.
        step(0, 1, 1, 2, 5);
        step(0, 1, 1, 1, 7);
        step(0, 1, 1, 0, 9);
        mux_exp[0] = 9; mux_exp[1] = 7; mux_exp[2] = 5; mux_exp[3] = 0;
        i_set = 1'b0; i_ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_sel = 2'(k);
            #1;
            check_val("mux", int'(o_sel_val), mux_exp[k]);
        end
        step(0, 0, 0, 3, 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, s;
            int sl, v;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 9) < 2);
            sl = int'($urandom_range(0, 3));
            v  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 70))
                                             : int'($urandom_range(0, 255));
            step(r, e, s, sl, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Time-of-day core that sits directly downstream of the push-button input stage.
- Consumes its set-mode flag, 2-bit field select and 0..59 field value; maintains seconds/minutes/hours counters.
- Free-runs from a prescaled clock enable when not in set mode.
- Returns the currently selected field's value so the input stage can preload its value counter. Outputs also feed the display driver.

Parameters:
- TICKS_PER_SEC, 100_000_000: enabled i_clk cycles per second; minimum 2.
- HOURS_PER_DAY, 24: hour wrap modulus; legal values 12 or 24.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_ena  input  1  global clock enable; prescaler advances only when high.
- i_set  input  1  set-mode level from the input stage's write toggle; 1 = set mode, 0 = run mode.
- i_sel  input  2  field select: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- i_val  input  8  binary value for the selected field.
- o_sec  output  8  seconds, binary 0..59.
- o_min  output  8  minutes, binary 0..59.
- o_hr  output  8  hours, binary 0..HOURS_PER_DAY-1.
- o_sel_val  output  8  value of the field chosen by i_sel; 0 when i_sel=3.
- o_sec_pulse  output  1  one-cycle strobe on each second increment.
- o_running  output  1  registered copy of ~i_set.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - sec/min/hr = 0, prescaler = 0, o_sec_pulse = 0, o_running = 1.
  - Reset overrides set mode, i_ena and any in-progress carry.
- Prescaler:
  - Counter of width clog2(TICKS_PER_SEC).
  - Advances by 1 on cycles with i_ena=1 and i_set=0.
  - On the cycle it holds TICKS_PER_SEC-1 with i_ena=1, it wraps to 0 and a second tick occurs.
  - With i_ena=0, prescaler and all time registers hold.
- Second tick (run mode), all updates in the same edge:
  - sec+1. At 59: sec=0, min+1.
  - min at 59 with carry: min=0, hr+1.
  - hr at HOURS_PER_DAY-1 with carry: hr=0.
  - Full rollover 23:59:59 -> 00:00:00 happens in one edge.
- o_sec_pulse:
  - Registered; high for exactly the one cycle after the edge on which the tick was taken.
  - Never asserted in set mode.
- Set mode (i_set=1):
  - Prescaler is forced to 0 every cycle; no ticks.
  - Each cycle, the field chosen by i_sel loads i_val, but only if i_val is in range: <60 for sec/min, <HOURS_PER_DAY for hr.
  - Out-of-range i_val is ignored; the field holds.
  - i_sel=3 writes nothing.
  - Fields not selected hold.
  - Write latency: one cycle (i_val at edge N is visible on the field output after edge N).
- Leaving set mode (i_set 1->0):
  - Prescaler starts from 0.
  - First tick occurs after TICKS_PER_SEC enabled cycles.
  - No tick is generated by the transition itself.
- Entering set mode mid-second: the partial prescaler count is discarded.
- o_sel_val:
  - Combinational mux of the registered fields by the current i_sel.
  - Zero latency relative to i_sel; reflects a set-mode write one cycle after that write.
- o_running: registered ~i_set, one cycle latency; reset value 1.
- Arithmetic:
  - All fields are 8-bit unsigned binary; upper bits are always 0 in legal states.
  - No BCD inside this block.

Test Plan:
- TICKS_PER_SEC=4, i_ena=1, i_set=0, reset then run 4×60 cycles:
  - sec steps 0..59, then returns to 0 with min=1.
  - o_sec_pulse is seen exactly 60 times, each one cycle wide.
- Set mode walk:
  - i_set=1; i_sel=2, i_val=23; i_sel=1, i_val=59; i_sel=0, i_val=58; then i_set=0 → fields read 23:59:58.
  - After 8 enabled cycles → 00:00:00, with exactly 2 pulses.
- Range rejection: i_set=1, i_sel=2, i_val=24 → hr holds previous value; i_sel=0, i_val=60 → sec holds.
- Enable gating: run with i_ena toggling 1,0,1,0 → one second tick per 8 clocks; all registers frozen on i_ena=0 cycles.
- Reset mid-operation:
  - i_reset at 12:34:56 with prescaler=2 → next cycle 00:00:00, o_sec_pulse=0, o_running=1.
  - Reset asserted while i_set=1, i_sel=0, i_val=30 → sec=0.
- o_sel_val mux: load 05:07:09 → i_sel=0,1,2,3 gives 9,7,5,0 combinationally in the same cycle.
